// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch sequencer.
package fetch_pkg;

  localparam int INST_W     = 32;
  localparam int ADDR_W     = 8;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } q_entry_t;

endpackage

// File: rtl/fetch_inst_queue.sv
// 4-entry in-order {pc,inst} FIFO with up to two pushes and two pops per cycle.
module inst_queue
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic [1:0] push_cnt_i,
  input  q_entry_t   push0_i,
  input  q_entry_t   push1_i,
  input  logic [1:0] pop_cnt_i,
  output q_entry_t   head0_o,
  output q_entry_t   head1_o,
  output logic [2:0] count_o
);

  q_entry_t   mem_q [4];
  logic [1:0] rd_q, rd_d;
  logic [1:0] wr_q, wr_d;
  logic [2:0] count_q, count_d;

  always_comb begin
    rd_d    = rd_q + pop_cnt_i;
    wr_d    = wr_q + push_cnt_i;
    count_d = count_q - {1'b0, pop_cnt_i} + {1'b0, push_cnt_i};
    if (flush_i) begin
      rd_d    = 2'd0;
      wr_d    = 2'd0;
      count_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 2'd0;
      wr_q    <= 2'd0;
      count_q <= 3'd0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Entries being popped this cycle may be overwritten: heads read pre-edge values.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (push_cnt_i != 2'd0) mem_q[wr_q] <= push0_i;
      if (push_cnt_i == 2'd2) mem_q[wr_q + 2'd1] <= push1_i;
    end
  end

  assign head0_o = mem_q[rd_q];
  assign head1_o = mem_q[rd_q + 2'd1];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Dual-issue fetch sequencer: PC, slot validation, redirect/flush priority.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   FETCH | presenting PC to memory, pushing valid slots into the queue
//   HALT  | fetched past END_PC; queue drains, start/redirect resume
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_PC = 8'h00,
  parameter logic [ADDR_W-1:0] END_PC   = 8'h78,
  parameter int                QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] inst_address,
  input  logic [INST_W-1:0] mem_inst1,
  input  logic [INST_W-1:0] mem_inst2,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              issue0_valid,
  output logic [INST_W-1:0] issue0_inst,
  output logic [ADDR_W-1:0] issue0_pc,
  output logic              issue1_valid,
  output logic [INST_W-1:0] issue1_inst,
  output logic [ADDR_W-1:0] issue1_pc,
  input  logic [1:0]        issue_accept,
  output logic              busy,
  output logic              halted
);

  localparam logic [8:0] END9   = {1'b0, END_PC};
  localparam logic [2:0] DEPTH3 = 3'(QDEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              flush;
  logic [1:0]        push_cnt, pop_cnt;
  q_entry_t          push0, push1, head0, head1;
  logic [2:0]        count;

  logic [8:0]        pc9, pc_adv;
  logic              slot_a, slot_b;
  logic [1:0]        nslots, acc_lim, acc_eff;
  logic [2:0]        free_after;
  logic [ADDR_W-1:0] redir_tgt;
  logic              unused_redir_bits;

  assign unused_redir_bits = ^redirect_pc[1:0];
  assign redir_tgt         = {redirect_pc[7:2], 2'b00};

  assign pc9        = {1'b0, pc_q};
  assign slot_a     = (pc9 <= END9);
  assign slot_b     = ((pc9 + 9'd4) <= END9) && (pc_q != 8'hFC);
  assign nslots     = {1'b0, slot_a} + {1'b0, slot_b};
  assign pc_adv     = pc9 + {5'd0, nslots, 2'b00};
  assign acc_lim    = (issue_accept > 2'd2) ? 2'd2 : issue_accept;
  assign acc_eff    = ({1'b0, acc_lim} > count) ? count[1:0] : acc_lim;
  assign free_after = DEPTH3 - count + {1'b0, acc_eff};

  assign push0 = '{pc: pc_q,          inst: mem_inst1};
  assign push1 = '{pc: pc_q + 8'd4,   inst: mem_inst2};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush    = 1'b0;
    push_cnt = 2'd0;
    pop_cnt  = acc_eff;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = START_PC;
          flush   = 1'b1;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_d  = redir_tgt;
          flush = 1'b1;
        end else if (nslots == 2'd0) begin
          state_d = HALT;
        end else if ({1'b0, nslots} <= free_after) begin
          push_cnt = nslots;
          // Past END_PC: keep PC on the last fetched address.
          if (pc_adv > END9) state_d = HALT;
          else               pc_d    = pc_adv[7:0];
        end
      end
      HALT: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = START_PC;
          flush   = 1'b1;
        end else if (redirect_valid) begin
          state_d = FETCH;
          pc_d    = redir_tgt;
          flush   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) pop_cnt = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(issue_accept == 2'd2 && count == 3'd1));
    end
  end

  inst_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .push_cnt_i(push_cnt),
    .push0_i   (push0),
    .push1_i   (push1),
    .pop_cnt_i (pop_cnt),
    .head0_o   (head0),
    .head1_o   (head1),
    .count_o   (count)
  );

  assign inst_address = pc_q;
  assign issue0_valid = (count >= 3'd1);
  assign issue1_valid = (count >= 3'd2);
  assign issue0_inst  = issue0_valid ? head0.inst : '0;
  assign issue0_pc    = issue0_valid ? head0.pc   : '0;
  assign issue1_inst  = issue1_valid ? head1.inst : '0;
  assign issue1_pc    = issue1_valid ? head1.pc   : '0;
  assign busy         = (state_q == FETCH) || (count != 3'd0);
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: three instances with different END_PC values.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n, start, redirect_valid;
  logic [7:0] redirect_pc;
  logic [1:0] acc_a, acc_b, acc_c;

  logic [7:0]  addr_a, addr_b, addr_c;
  logic [31:0] m1_a, m2_a, m1_b, m2_b, m1_c, m2_c;
  logic        v0_a, v1_a, v0_b, v1_b, v0_c, v1_c;
  logic [31:0] i0_a, i1_a, i0_b, i1_b, i0_c, i1_c;
  logic [7:0]  p0_a, p1_a, p0_b, p1_b, p0_c, p1_c;
  logic        busy_a, busy_b, busy_c, halt_a, halt_b, halt_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {24'hC0DE00, a};
  endfunction

  assign m1_a = mem_word(addr_a);  assign m2_a = mem_word(addr_a + 8'd4);
  assign m1_b = mem_word(addr_b);  assign m2_b = mem_word(addr_b + 8'd4);
  assign m1_c = mem_word(addr_c);  assign m2_c = mem_word(addr_c + 8'd4);

  fetch_ctrl #(.START_PC(8'h00), .END_PC(8'h0C)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .inst_address(addr_a),
    .mem_inst1(m1_a), .mem_inst2(m2_a),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .issue0_valid(v0_a), .issue0_inst(i0_a), .issue0_pc(p0_a),
    .issue1_valid(v1_a), .issue1_inst(i1_a), .issue1_pc(p1_a),
    .issue_accept(acc_a), .busy(busy_a), .halted(halt_a));

  fetch_ctrl #(.START_PC(8'h00), .END_PC(8'h08)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .inst_address(addr_b),
    .mem_inst1(m1_b), .mem_inst2(m2_b),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .issue0_valid(v0_b), .issue0_inst(i0_b), .issue0_pc(p0_b),
    .issue1_valid(v1_b), .issue1_inst(i1_b), .issue1_pc(p1_b),
    .issue_accept(acc_b), .busy(busy_b), .halted(halt_b));

  fetch_ctrl dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .inst_address(addr_c),
    .mem_inst1(m1_c), .mem_inst2(m2_c),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .issue0_valid(v0_c), .issue0_inst(i0_c), .issue0_pc(p0_c),
    .issue1_valid(v1_c), .issue1_inst(i1_c), .issue1_pc(p1_c),
    .issue_accept(acc_c), .busy(busy_c), .halted(halt_c));

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    acc_a = 2'd0; acc_b = 2'd0; acc_c = 2'd0;

    // reset values
    #2;
    chk("rst_v0",   v0_a, 1'b0);
    chk("rst_v1",   v1_a, 1'b0);
    chk("rst_i0",   i0_a, 32'h0);
    chk("rst_p1",   p1_a, 8'h0);
    chk("rst_addr", addr_a, 8'h00);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_halt", halt_a, 1'b0);
    #6 rst_n = 1'b1;
    tick();
    chk("idle_busy", busy_a, 1'b0);

    // dual issue, END_PC=0x0C, accept 2
    acc_a = 2'd2; start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_busy", busy_a, 1'b1);
    chk("t1_v0_n", v0_a, 1'b0);
    tick();
    chk("t1_v0",   v0_a, 1'b1);
    chk("t1_p0",   p0_a, 8'h00);
    chk("t1_i0",   i0_a, mem_word(8'h00));
    chk("t1_p1",   p1_a, 8'h04);
    chk("t1_i1",   i1_a, mem_word(8'h04));
    chk("t1_addr", addr_a, 8'h08);
    tick();
    chk("t1_p0b",  p0_a, 8'h08);
    chk("t1_p1b",  p1_a, 8'h0C);
    chk("t1_i1b",  i1_a, mem_word(8'h0C));
    chk("t1_halt", halt_a, 1'b1);
    chk("t1_addrh", addr_a, 8'h08);
    tick();
    chk("t1_drain", v0_a, 1'b0);
    chk("t1_idle",  busy_a, 1'b0);
    acc_a = 2'd0;

    // accept held at 0: queue fills, PC holds
    pulse_reset();
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    chk("t2_p0",   p0_a, 8'h00);
    chk("t2_p1",   p1_a, 8'h04);
    chk("t2_addr", addr_a, 8'h08);
    tick();
    chk("t2_p0s",  p0_a, 8'h00);
    chk("t2_p1s",  p1_a, 8'h04);
    chk("t2_addrs", addr_a, 8'h08);
    acc_a = 2'd1;
    tick();
    chk("t2_pop1", p0_a, 8'h04);
    chk("t2_pop1b", p1_a, 8'h08);
    acc_a = 2'd2;
    tick();
    chk("t2_last", p0_a, 8'h0C);
    chk("t2_v1",   v1_a, 1'b0);
    acc_a = 2'd1;
    tick();
    chk("t2_empty", busy_a, 1'b0);
    acc_a = 2'd0;

    // END_PC=0x08, accept 1: last fetch pushes slot A only
    pulse_reset();
    acc_b = 2'd1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t3_p0a", p0_b, 8'h00);
    chk("t3_p1a", p1_b, 8'h04);
    tick();
    chk("t3_p0b", p0_b, 8'h04);
    chk("t3_p1b", p1_b, 8'h08);
    chk("t3_i1b", i1_b, mem_word(8'h08));
    chk("t3_halt", halt_b, 1'b1);
    tick();
    chk("t3_p0c", p0_b, 8'h08);
    chk("t3_v1c", v1_b, 1'b0);
    tick();
    chk("t3_v0d", v0_b, 1'b0);
    chk("t3_busy", busy_b, 1'b0);
    acc_b = 2'd0;

    // redirect while full, END_PC=0x78
    pulse_reset();
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_stall", addr_c, 8'h10);
    chk("t4_p0",    p0_c, 8'h00);
    acc_c = 2'd2; redirect_valid = 1'b1; redirect_pc = 8'h23;
    tick();
    redirect_valid = 1'b0; acc_c = 2'd0;
    chk("t4_v0",   v0_c, 1'b0);
    chk("t4_v1",   v1_c, 1'b0);
    chk("t4_addr", addr_c, 8'h20);
    tick();
    chk("t4_p0r",  p0_c, 8'h20);
    chk("t4_i0r",  i0_c, mem_word(8'h20));
    chk("t4_p1r",  p1_c, 8'h24);
    chk("t4_addr2", addr_c, 8'h28);

    // async reset mid-FETCH
    rst_n = 1'b0;
    #1;
    chk("t5_addr", addr_c, 8'h00);
    chk("t5_v0",   v0_c, 1'b0);
    chk("t5_p0",   p0_c, 8'h00);
    chk("t5_busy", busy_c, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk("t5_idle", busy_c, 1'b0);
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t5_p0r", p0_c, 8'h00);
    chk("t5_p1r", p1_c, 8'h04);

    // HALT: start beats redirect, then redirect alone
    tick();
    chk("t6_halt", halt_a, 1'b1);
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h08;
    tick();
    start = 1'b0; redirect_valid = 1'b0;
    chk("t6_run",  halt_a, 1'b0);
    chk("t6_addr", addr_a, 8'h00);
    chk("t6_v0",   v0_a, 1'b0);
    tick();
    chk("t6_p0",   p0_a, 8'h00);
    tick();
    chk("t6_halt2", halt_a, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 8'h06;
    tick();
    redirect_valid = 1'b0;
    chk("t6_rhalt", halt_a, 1'b0);
    chk("t6_raddr", addr_a, 8'h04);
    chk("t6_rv0",   v0_a, 1'b0);
    tick();
    chk("t6_rp0",   p0_a, 8'h04);
    chk("t6_rp1",   p1_a, 8'h08);
    chk("t6_raddr2", addr_a, 8'h0C);
    tick();
    chk("t6_rhalt2", halt_a, 1'b1);
    chk("t6_raddr3", addr_a, 8'h0C);

    // redirect target beyond END_PC
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    chk("t7_run",  halt_a, 1'b0);
    chk("t7_busy", busy_a, 1'b1);
    chk("t7_addr", addr_a, 8'h40);
    tick();
    chk("t7_halt", halt_a, 1'b1);
    chk("t7_v0",   v0_a, 1'b0);
    chk("t7_idle", busy_a, 1'b0);
    chk("t7_addr2", addr_a, 8'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Dual-issue instruction fetch sequencer. Drives the byte address into the 8-bit-addressed instruction memory and captures the two words it returns (word at addr, word at addr+4).
- Buffers fetched words in a 4-entry in-order queue and issues up to two instructions per cycle to decode through a valid/accept handshake.
- Handles start, branch redirect with flush, and halt at the end of the program.

Parameters:
- START_PC, 8'h00, byte address loaded into PC at reset and on start.
- END_PC, 8'h78, last valid instruction address (inclusive, 4-aligned). Fetch past it halts.
- QDEPTH, 4, instruction queue entries. Fixed at 4; the RTL need not support other values.

Ports:
- clk, input, 1, system clock (rising edge).
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, pulse; begins fetching from START_PC (honoured in IDLE or HALT).
- inst_address, output, 8, byte address to instruction memory (= PC register).
- mem_inst1, input, 32, memory word at inst_address (combinational return).
- mem_inst2, input, 32, memory word at inst_address+4.
- redirect_valid, input, 1, branch/jump redirect.
- redirect_pc, input, 8, redirect target; bits [1:0] are ignored (forced to 0).
- issue0_valid, output, 1, oldest queued instruction is available.
- issue0_inst, output, 32, oldest instruction.
- issue0_pc, output, 8, PC of issue0_inst.
- issue1_valid, output, 1, second-oldest instruction is available; only asserted when issue0_valid is asserted.
- issue1_inst, output, 32, second-oldest instruction.
- issue1_pc, output, 8, PC of issue1_inst.
- issue_accept, input, 2, number of instructions decode consumes this cycle (0/1/2).
- busy, output, 1, state is FETCH or the queue is non-empty.
- halted, output, 1, state is HALT.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; PC=START_PC; queue empty (rd/wr pointers 0, count 0).
  - All issue*_valid=0; issue*_inst=0; issue*_pc=0; busy=0; halted=0; inst_address=START_PC.
  - Reset asserted mid-operation discards the queue and the fetch in progress immediately.
- States:
  - IDLE -> FETCH on start (PC<=START_PC).
  - FETCH -> HALT when PC > END_PC after a push, or when no valid slot remains.
  - HALT -> FETCH on start (PC<=START_PC, queue flushed) or on redirect_valid.
  - IDLE ignores redirect_valid.
- Fetch, FETCH state only:
  - Memory read is combinational; words are captured at the clock edge in the same cycle inst_address is presented.
  - Slot A (mem_inst1, pc=PC) is valid when PC<=END_PC.
  - Slot B (mem_inst2, pc=PC+4) is valid when PC+4<=END_PC and PC!=8'hFC. PC+4 is compared in 9 bits, so there is no wrap-around fetch.
  - Push happens only if free entries, counted after this cycle's accept, >= number of valid slots. Otherwise stall: PC holds and nothing is pushed.
  - On push, PC advances by 4 times the number of slots pushed, computed in 9 bits. If the result exceeds END_PC or 8'hFF, go to HALT and hold PC.
- Issue:
  - issue0 = queue head; issue1 = head+1. Both are driven combinationally from registered queue state.
  - Valid flags follow count (count>=1, count>=2).
  - Accept is clamped to count. Accept of 2 with count 1 pops 1 and is flagged by an assertion in simulation.
  - Pop and push in the same cycle are legal; a full queue with accept 2 and 2 valid slots pushes in that cycle.
- Latency: start at edge N. First push at edge N+1. issue0_valid high after edge N+1, i.e. 2 edges from the start sample.
- Redirect has highest priority in its cycle:
  - Queue is flushed (count<=0) and that cycle's accept and push are discarded.
  - PC<={redirect_pc[7:2],2'b00}; state<=FETCH.
  - issue*_valid=0 the following cycle; first redirected instruction is valid 2 cycles after redirect_valid is sampled.
- Redirect and start in the same cycle: start wins.
- Redirect target > END_PC: enter FETCH, then HALT on the next edge with nothing pushed.
- Queue wrap: pointers are 2-bit and wrap modulo 4. count is 3-bit, range 0..4.

Decomposition:
- Shared package fetch_pkg: state encoding (IDLE=2'd0, FETCH=2'd1, HALT=2'd2), INST_W=32, ADDR_W=8, INST_BYTES=4.
- One sub-module is natural: inst_queue, a 4-entry {pc,inst} FIFO. It accepts 0/1/2 pushes and 0/1/2 pops per cycle and exposes head, head+1 and count.
- fetch_ctrl holds the FSM, PC, slot validation and redirect/flush priority.

Test Plan:
- Reset then start with END_PC=8'h0C and mem words W0..W3, issue_accept=2 always -> pairs (0x00,0x04) then (0x08,0x0C) issue on consecutive cycles; halted=1 after the last push; busy=0 once the queue drains.
- issue_accept held at 0 from start -> queue fills to 4 by edge N+2; inst_address holds at 8'h08 with no further push; issue0_pc=0x00, issue1_pc=0x04 stay stable.
- END_PC=8'h08, accept=1 each cycle -> last fetch at PC=0x08 pushes only slot A; issue order 0x00, 0x04, 0x08; issue1_valid never shows pc 0x0C.
- redirect_valid with redirect_pc=8'h23 while queue is full and accept=2 -> PC becomes 0x20; all valids are 0 for one cycle; next issue0_pc=0x20 and issue1_pc=0x24; stale entries are never issued.
- rst_n pulsed low asynchronously between edges mid-FETCH -> outputs zero immediately and inst_address=START_PC; after release and start, fetch restarts at START_PC.
- start and redirect_valid asserted together while in HALT -> PC=START_PC (start wins); redirect alone in HALT resumes at its target.
